// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and default widths for the CPU memory-side blocks.
//   arb_state_e : memory arbiter FSM states (IDLE, ISSUE, WAIT)
//   req_id_e    : requester identity (REQ_IF = instruction fetch, REQ_D = data)
//   *_DEF       : default address/data widths and arbiter timeout
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_e;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_D  = 1'b1
   } req_id_e;

   // The requester that is not 'id'; used for round-robin tie breaking.
   function automatic req_id_e other_req(input req_id_e id);
      return (id == REQ_D) ? REQ_IF : REQ_D;
   endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// -----------------------------------------------------------------------------
// mem_arb_timer
// Transaction watchdog for mem_arbiter. Counts cycles spent in ISSUE/WAIT.
//   clk     : clock, rising edge
//   reset   : asynchronous, active-low reset (counter -> 0)
//   clear   : restart the count (asserted on the grant edge)
//   enable  : count this cycle (arbiter in ISSUE or WAIT)
//   expired : the count reaches TIMEOUT at the coming edge
// -----------------------------------------------------------------------------
module mem_arb_timer #(
   parameter int TIMEOUT = cpu_pkg::TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Flag the edge on which the count becomes TIMEOUT so the error response
   // is registered on that same edge (TIMEOUT edges after entering ISSUE).
   assign expired = enable && !clear && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-requester (instruction fetch, load/store) arbiter onto a single
// valid/ready memory command port with a separate completion (mem_rvalid).
// One transaction in flight at a time: IDLE -> ISSUE -> WAIT -> IDLE.
// A watchdog (mem_arb_timer) turns a stuck transaction into an error response.
//
// Ports
//   clk, reset                 : clock (rising edge), async active-low reset
//   if_req/if_addr             : fetch read request
//   if_gnt/if_rvalid/if_rdata/if_err : fetch grant pulse and response
//   d_req/d_we/d_addr/d_wdata/d_wstrb : load/store request
//   d_gnt/d_rvalid/d_rdata/d_err      : data grant pulse and response
//   mem_valid/mem_ready/mem_we/mem_addr/mem_wdata/mem_wstrb : memory command
//   mem_rvalid/mem_rdata       : memory completion (reads and writes)
//
// Build option
//   MEM_ARB_RR_EN : when defined, ties go to the requester not granted last
//                   (round robin); otherwise the data port always wins ties.
// -----------------------------------------------------------------------------
module mem_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                clk,
   input  logic                reset,
   // instruction fetch
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_err,
   // load/store
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_err,
   // memory
   output logic                mem_valid,
   input  logic                mem_ready,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   arb_state_e          state_q;
   req_id_e             id_q;
   req_id_e             winner_d;

   logic                if_gnt_q, if_rvalid_q, if_err_q;
   logic [DATA_W-1:0]   if_rdata_q;
   logic                d_gnt_q, d_rvalid_q, d_err_q;
   logic [DATA_W-1:0]   d_rdata_q;
   logic                mem_valid_q, mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [DATA_W/8-1:0] mem_wstrb_q;

   logic                any_req;
   logic                tmr_clear;
   logic                tmr_en;
   logic                expired;
   logic                resp_ok;
   logic                resp_err;

   assign any_req   = if_req | d_req;
   assign tmr_clear = (state_q == IDLE) && any_req;
   assign tmr_en    = (state_q == ISSUE) || (state_q == WAIT);
   // Timeout takes priority over a completion arriving on the same edge.
   assign resp_err  = expired;
   assign resp_ok   = (state_q == WAIT) && mem_rvalid && !expired;

`ifdef MEM_ARB_RR_EN
   req_id_e last_q;

   always_comb begin
      winner_d = d_req ? REQ_D : REQ_IF;
      if (if_req && d_req) begin
         winner_d = other_req(last_q);
      end
   end
`else
   assign winner_d = d_req ? REQ_D : REQ_IF;
`endif

   mem_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clear),
      .enable  (tmr_en),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         id_q        <= REQ_IF;
         if_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         if_err_q    <= 1'b0;
         if_rdata_q  <= '0;
         d_gnt_q     <= 1'b0;
         d_rvalid_q  <= 1'b0;
         d_err_q     <= 1'b0;
         d_rdata_q   <= '0;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
`ifdef MEM_ARB_RR_EN
         last_q      <= REQ_IF;
`endif
      end else begin
         // Grant and response outputs are single-cycle pulses.
         if_gnt_q    <= 1'b0;
         d_gnt_q     <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_err_q    <= 1'b0;
         d_err_q     <= 1'b0;

         case (state_q)
            IDLE: begin
               if (any_req) begin
                  id_q        <= winner_d;
                  state_q     <= ISSUE;
                  mem_valid_q <= 1'b1;
`ifdef MEM_ARB_RR_EN
                  last_q      <= winner_d;
`endif
                  if (winner_d == REQ_D) begin
                     d_gnt_q     <= 1'b1;
                     mem_we_q    <= d_we;
                     mem_addr_q  <= d_addr;
                     mem_wdata_q <= d_wdata;
                     mem_wstrb_q <= d_wstrb;
                  end else begin
                     // Fetches are always reads with no byte enables.
                     if_gnt_q    <= 1'b1;
                     mem_we_q    <= 1'b0;
                     mem_addr_q  <= if_addr;
                     mem_wdata_q <= '0;
                     mem_wstrb_q <= '0;
                  end
               end
            end
            ISSUE: begin
               if (resp_err) begin
                  mem_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end else if (mem_ready) begin
                  mem_valid_q <= 1'b0;
                  state_q     <= WAIT;
               end
            end
            WAIT: begin
               if (resp_err || resp_ok) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               mem_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase

         // Response to whoever owns the transaction; rdata only moves here,
         // so it holds its last value between responses.
         if (resp_err || resp_ok) begin
            if (id_q == REQ_D) begin
               d_rvalid_q <= 1'b1;
               d_err_q    <= resp_err;
               d_rdata_q  <= resp_err ? '0 : mem_rdata;
            end else begin
               if_rvalid_q <= 1'b1;
               if_err_q    <= resp_err;
               if_rdata_q  <= resp_err ? '0 : mem_rdata;
            end
         end
      end
   end

   assign if_gnt    = if_gnt_q;
   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign if_err    = if_err_q;
   assign d_gnt     = d_gnt_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_rdata   = d_rdata_q;
   assign d_err     = d_err_q;
   assign mem_valid = mem_valid_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;

endmodule
